// File: rtl/mcpu_pkg.sv
// rtl/mcpu_pkg.sv - opcodes, FSM states and ALU controls shared by the multi-cycle core
package mcpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_LW   = 4'b0101;
  localparam logic [3:0] OP_SW   = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_e;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

  // ADDI, LW and SW all use the adder (immediate add / effective address)
  function automatic alu_op_e alu_ctrl(input logic [3:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  // Everything above BEQ (explicit HALT included) stops the core
  function automatic logic op_legal(input logic [3:0] op);
    return op <= OP_BEQ;
  endfunction

endpackage

// File: rtl/mcpu_regfile.sv
// rtl/mcpu_regfile.sv - 4-entry register file, two read ports, one write port, r0 reads zero
module mcpu_regfile
  import mcpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [1:0]        ra_i,
  input  logic [1:0]        rb_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o,
  input  logic              we_i,
  input  logic [1:0]        wa_i,
  input  logic [DATA_W-1:0] wdata_i
);

  logic [DATA_W-1:0] regs_q [4];

  // Writes to r0 are dropped so entry 0 stays at its reset value
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else if (we_i && (wa_i != 2'd0)) begin
      regs_q[wa_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (ra_i == 2'd0) ? '0 : regs_q[ra_i];
  assign rdata_b_o = (rb_i == 2'd0) ? '0 : regs_q[rb_i];

endmodule

// File: rtl/mcpu_core.sv
// rtl/mcpu_core.sv - multi-cycle 16-bit-ISA core, shared req/ack memory port; MCPU_INSTRET_EN adds retired-instruction counter
module mcpu_core
  import mcpu_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 10,
  parameter int RESET_PC = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [15:0]       ir,
  output logic [ADDR_W-1:0] pc,
  output logic              wb_en,
  output logic [DATA_W-1:0] wb_data,
  output logic              halted,
  output logic [31:0]       instret
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d, br_off;
  logic [15:0]       ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [DATA_W-1:0] rf_a, rf_b, imm_ext, opb, alu_y;
  logic [3:0]        op;
  logic [1:0]        rs, rt, rd;
  logic              rr_type, is_sw;

  assign op      = ir_q[15:12];
  assign rs      = ir_q[11:10];
  assign rt      = ir_q[9:8];
  assign rd      = ir_q[7:6];
  assign imm_ext = DATA_W'($signed(ir_q[7:0]));
  assign br_off  = ADDR_W'($signed(ir_q[7:0]));
  assign rr_type = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
                   (op == OP_OR)  || (op == OP_SLT);
  assign is_sw   = (op == OP_SW);
  assign opb     = rr_type ? b_q : imm_ext;

  mcpu_regfile #(.DATA_W(DATA_W)) u_regfile (
    .clock     (clock),
    .reset_n   (reset_n),
    .ra_i      (rs),
    .rb_i      (rt),
    .rdata_a_o (rf_a),
    .rdata_b_o (rf_b),
    .we_i      (state_q == WB),
    .wa_i      (rr_type ? rd : rt),
    .wdata_i   (res_q)
  );

  // ALU on the operand latches; also forms the LW/SW effective address
  always_comb begin
    alu_y = '0;
    case (alu_ctrl(op))
      ALU_ADD: alu_y = a_q + opb;
      ALU_SUB: alu_y = a_q - opb;
      ALU_AND: alu_y = a_q & opb;
      ALU_OR:  alu_y = a_q | opb;
      ALU_SLT: alu_y[0] = $signed(a_q) < $signed(opb);
      default: alu_y = '0;
    endcase
  end

  // Memory port is combinational from state; gated by reset_n so it drops the moment reset asserts
  assign mem_req   = reset_n && ((state_q == FETCH) || (state_q == MEM));
  assign mem_we    = mem_req && (state_q == MEM) && is_sw;
  assign mem_addr  = !mem_req ? '0 : ((state_q == MEM) ? addr_q : pc_q);
  assign mem_wdata = mem_we ? b_q : '0;
  assign wb_en     = (state_q == WB);
  assign wb_data   = wb_en ? res_q : '0;
  assign halted    = (state_q == HALT);
  assign ir        = ir_q;
  assign pc        = pc_q;

  // Next-state and datapath-latch logic for the fetch/decode/exec/mem/wb sequence
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    addr_d  = addr_q;
    case (state_q)
      FETCH: if (mem_ack) begin
        ir_d    = mem_rdata[15:0];
        pc_d    = pc_q + 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        a_d     = rf_a;
        b_d     = rf_b;
        state_d = op_legal(op) ? EXEC : HALT;
      end
      EXEC: begin
        if (op == OP_BEQ) begin
          if (a_q == b_q) pc_d = pc_q + br_off;
          state_d = FETCH;
        end else if ((op == OP_LW) || is_sw) begin
          addr_d  = ADDR_W'(alu_y);
          state_d = MEM;
        end else begin
          res_d   = alu_y;
          state_d = WB;
        end
      end
      MEM: if (mem_ack) begin
        if (is_sw) begin
          state_d = FETCH;
        end else begin
          res_d   = mem_rdata;
          state_d = WB;
        end
      end
      WB:      state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH;
      pc_q    <= ADDR_W'(RESET_PC);
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      addr_q  <= addr_d;
    end
  end

`ifdef MCPU_INSTRET_EN
  logic        retire;
  logic [31:0] instret_q, instret_d;

  assign retire    = ((state_q == EXEC) && (op == OP_BEQ)) ||
                     ((state_q == MEM) && mem_ack && is_sw) ||
                     (state_q == WB);
  assign instret_d = instret_q + {31'd0, retire};
  assign instret   = instret_q;

  // Retired-instruction counter; HALT never reaches a retire point
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) instret_q <= '0;
    else          instret_q <= instret_d;
  end
`else
  assign instret = '0;
`endif

endmodule
